// File: rtl/spw_tx_encoder.sv
// rtl/spw_tx_encoder.sv - SpaceWire transmit character encoder
// Selects time-code/FCT/data/NULL at each character boundary and serialises it data-strobe encoded.
module spw_tx_encoder #(
    parameter int DIV_WIDTH = 7
) (
    input  logic                 pclk_tx,
    input  logic                 reset_tx,
    input  logic                 enable_tx,
    input  logic                 send_null_tx,
    input  logic                 send_fct_tx,
    input  logic                 send_data_tx,
    input  logic [DIV_WIDTH-1:0] tx_clk_div,
    input  logic                 fct_req,
    output logic                 fct_ack,
    input  logic                 txwrite_tx,
    input  logic [8:0]           data_tx_i,
    output logic                 data_ack,
    input  logic                 tickin_tx,
    input  logic [7:0]           timein_tx,
    output logic                 tick_ack,
    output logic                 tx_dout,
    output logic                 tx_sout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [13:0]          shreg_q, shreg_d;
    logic [3:0]           nbits_q, nbits_d;
    logic                 x_q, x_d;
    logic                 dout_q, dout_d;
    logic                 sout_q, sout_d;

    logic        tick, load;
    logic        sel_tc, sel_fct, sel_data;
    logic [13:0] nxt_bits;
    logic [3:0]  nxt_len;
    logic        nxt_x;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    // Next character is left-aligned; x_q is the XOR of the last sub-character already loaded.
    always_comb begin
        sel_tc   = tickin_tx && send_data_tx;
        sel_fct  = !sel_tc && fct_req && send_fct_tx;
        sel_data = !sel_tc && !sel_fct && txwrite_tx && send_data_tx;
        nxt_bits = {x_q, 3'b111, 4'b0100, 6'b0};
        nxt_len  = 4'd8;
        nxt_x    = 1'b0;
        if (sel_tc) begin
            nxt_bits = {x_q, 3'b111, 2'b10, rev8(timein_tx)};
            nxt_len  = 4'd14;
            nxt_x    = ^timein_tx;
        end else if (sel_fct) begin
            nxt_bits = {x_q, 3'b100, 10'b0};
            nxt_len  = 4'd4;
            nxt_x    = 1'b0;
        end else if (sel_data) begin
            if (data_tx_i[8]) begin
                nxt_bits = {x_q, 1'b1, (data_tx_i[0] ? 2'b10 : 2'b01), 10'b0};
                nxt_len  = 4'd4;
                nxt_x    = 1'b1;
            end else begin
                nxt_bits = {~x_q, 1'b0, rev8(data_tx_i[7:0]), 4'b0};
                nxt_len  = 4'd10;
                nxt_x    = ^data_tx_i[7:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        nbits_d  = nbits_q;
        x_d      = x_q;
        dout_d   = dout_q;
        sout_d   = sout_q;
        tick     = 1'b0;
        load     = 1'b0;
        fct_ack  = 1'b0;
        data_ack = 1'b0;
        tick_ack = 1'b0;
        if (state_q == ST_IDLE || !enable_tx) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            shreg_d = '0;
            nbits_d = 4'd0;
            x_d     = 1'b0;
            dout_d  = 1'b0;
            sout_d  = 1'b0;
            if (state_q == ST_IDLE && enable_tx && send_null_tx) begin
                state_d = ST_SHIFT;
                shreg_d = {1'b0, 3'b111, 4'b0100, 6'b0};
                nbits_d = 4'd8;
            end
        end else begin
            tick  = (cnt_q >= tx_clk_div);
            cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
            if (tick) begin
                dout_d = shreg_q[13];
                sout_d = (shreg_q[13] != dout_q) ? sout_q : ~sout_q;
                if (nbits_q == 4'd1) begin
                    load     = 1'b1;
                    shreg_d  = nxt_bits;
                    nbits_d  = nxt_len;
                    x_d      = nxt_x;
                    tick_ack = sel_tc;
                    fct_ack  = sel_fct;
                    data_ack = sel_data;
                end else begin
                    shreg_d = shreg_q << 1;
                    nbits_d = nbits_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge pclk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            nbits_q <= 4'd0;
            x_q     <= 1'b0;
            dout_q  <= 1'b0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            nbits_q <= nbits_d;
            x_q     <= x_d;
            dout_q  <= dout_d;
            sout_q  <= sout_d;
        end
    end

    assign tx_dout = dout_q;
    assign tx_sout = sout_q;

endmodule

// File: tb/tb_spw_tx_encoder.sv
// tb/tb_spw_tx_encoder.sv - bench for spw_tx_encoder
// A receiver-style decoder rebuilds characters from the serial stream and checks parity.
module tb_spw_tx_encoder;

    localparam int K_NULL = 0, K_FCT = 1, K_EOP = 2, K_EEP = 3, K_DATA = 4, K_TIME = 5, K_BAD = 6;

    logic       clk = 1'b0;
    logic       reset_tx;
    logic       enable_tx, send_null_tx, send_fct_tx, send_data_tx;
    logic [6:0] tx_clk_div;
    logic       fct_req, txwrite_tx, tickin_tx;
    logic [8:0] data_tx_i;
    logic [7:0] timein_tx;
    logic       fct_ack, data_ack, tick_ack, tx_dout, tx_sout;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fct_ack_cnt = 0;
    bit   rxq[$];
    int   rxt[$];
    logic last_ds = 1'b0;
    logic dec_x = 1'b0;
    bit   mon_on = 1'b0;
    bit   stalled = 1'b0;

    spw_tx_encoder #(.DIV_WIDTH(7)) dut (
        .pclk_tx(clk), .reset_tx(reset_tx), .enable_tx(enable_tx),
        .send_null_tx(send_null_tx), .send_fct_tx(send_fct_tx), .send_data_tx(send_data_tx),
        .tx_clk_div(tx_clk_div), .fct_req(fct_req), .fct_ack(fct_ack),
        .txwrite_tx(txwrite_tx), .data_tx_i(data_tx_i), .data_ack(data_ack),
        .tickin_tx(tickin_tx), .timein_tx(timein_tx), .tick_ack(tick_ack),
        .tx_dout(tx_dout), .tx_sout(tx_sout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A new bit is any change of D xor S, since that toggles once per bit period.
    task automatic step();
        @(negedge clk);
        cyc++;
        fct_ack_cnt += int'(fct_ack);
        if (mon_on && ((tx_dout ^ tx_sout) !== last_ds)) begin
            rxq.push_back(tx_dout);
            rxt.push_back(cyc);
            last_ds = tx_dout ^ tx_sout;
        end
    endtask

    task automatic need(input int n);
        int c = 0;
        while (rxq.size() < n && !stalled) begin
            step();
            c++;
            if (c > 3000) begin
                stalled = 1'b1;
                chk("rx_timeout", 0, 1);
            end
        end
    endtask

    task automatic read_bits(input int n, output logic [7:0] v);
        need(n);
        v = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (rxq.size() > 0) v[i] = rxq.pop_front();
        end
    endtask

    task automatic read_sub(output logic flag, output logic [7:0] v);
        logic [7:0] pf;
        read_bits(2, pf);
        flag = pf[1];
        read_bits(flag ? 2 : 8, v);
        chk("parity", pf[0], 1'b1 ^ dec_x ^ flag);
        dec_x = flag ? (v[0] ^ v[1]) : ^v;
    endtask

    task automatic recv_token(output int k, output logic [7:0] v);
        logic       f, f2;
        logic [7:0] a, b;
        read_sub(f, a);
        v = 8'h00;
        if (!f) begin
            k = K_DATA;
            v = a;
        end else begin
            case ({a[0], a[1]})
                2'b00:   k = K_FCT;
                2'b01:   k = K_EOP;
                2'b10:   k = K_EEP;
                default: begin
                    read_sub(f2, b);
                    if (!f2) begin
                        k = K_TIME;
                        v = b;
                    end else if ({b[0], b[1]} == 2'b00) begin
                        k = K_NULL;
                    end else begin
                        k = K_BAD;
                    end
                end
            endcase
        end
    endtask

    task automatic expect_token(input int ek, input logic [7:0] ev, input string tag);
        int         k;
        logic [7:0] v;
        int         n = 0;
        do begin
            recv_token(k, v);
            n++;
        end while (k == K_NULL && n < 40 && !stalled);
        chk({tag, "_kind"}, k, ek);
        if (ek == K_DATA || ek == K_TIME) chk({tag, "_value"}, v, ev);
    endtask

    // which: 0 data, 1 fct, 2 tick
    task automatic wait_ack(input int which, input string tag);
        logic [2:0] ackv = 3'b000;
        for (int c = 0; c < 500; c++) begin
            step();
            ackv = {tick_ack, fct_ack, data_ack};
            if (ackv != 3'b000) break;
        end
        chk({tag, "_ack"}, ackv, 32'(1 << which));
        step();
        chk({tag, "_ack_pulse"}, {tick_ack, fct_ack, data_ack}, 0);
    endtask

    task automatic check_first_null(input string tag);
        logic [7:0] dexp = 8'b0111_0100;
        logic [7:0] sexp = 8'b1101_1110;
        step();
        chk({tag, "_pre_d"}, tx_dout, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("%s_d%0d", tag, i), tx_dout, dexp[7-i]);
            chk($sformatf("%s_s%0d", tag, i), tx_sout, sexp[7-i]);
        end
    endtask

    initial begin
        int         k;
        logic [7:0] v;
        int         order[$];
        int         exp_o[3];
        bit         dt, df, dd;
        int         kind;
        logic [7:0] rv;

        reset_tx = 1'b1; enable_tx = 1'b0; send_null_tx = 1'b0; send_fct_tx = 1'b0;
        send_data_tx = 1'b0; tx_clk_div = 7'd0; fct_req = 1'b0; txwrite_tx = 1'b0;
        data_tx_i = 9'h000; tickin_tx = 1'b0; timein_tx = 8'h00;
        repeat (3) step();
        chk("rst_dout", tx_dout, 0);
        chk("rst_sout", tx_sout, 0);
        chk("rst_acks", {tick_ack, fct_ack, data_ack}, 0);
        reset_tx = 1'b0;
        repeat (3) step();
        chk("idle_dout", tx_dout, 0);

        mon_on = 1'b1;
        enable_tx = 1'b1; send_null_tx = 1'b1;
        check_first_null("null1");
        recv_token(k, v); chk("null1_tok", k, K_NULL);
        recv_token(k, v); chk("null2_tok", k, K_NULL);

        send_data_tx = 1'b1; txwrite_tx = 1'b1; data_tx_i = 9'h05A;
        wait_ack(0, "data5a");
        txwrite_tx = 1'b0;
        expect_token(K_DATA, 8'h5A, "data5a");
        recv_token(k, v); chk("after_data_null", k, K_NULL);

        send_fct_tx = 1'b1;
        for (int it = 0; it < 12; it++) begin
            kind = $urandom_range(0, 3);
            rv = 8'($urandom);
            tx_clk_div = 7'($urandom_range(0, 2));
            case (kind)
                0: begin
                    txwrite_tx = 1'b1; data_tx_i = {1'b0, rv};
                    wait_ack(0, $sformatf("rnd%0d", it)); txwrite_tx = 1'b0;
                    expect_token(K_DATA, rv, $sformatf("rnd%0d", it));
                end
                1: begin
                    txwrite_tx = 1'b1; data_tx_i = {1'b1, rv};
                    wait_ack(0, $sformatf("rnd%0d", it)); txwrite_tx = 1'b0;
                    expect_token(rv[0] ? K_EEP : K_EOP, 8'h00, $sformatf("rnd%0d", it));
                end
                2: begin
                    fct_req = 1'b1;
                    wait_ack(1, $sformatf("rnd%0d", it)); fct_req = 1'b0;
                    expect_token(K_FCT, 8'h00, $sformatf("rnd%0d", it));
                end
                default: begin
                    tickin_tx = 1'b1; timein_tx = rv;
                    wait_ack(2, $sformatf("rnd%0d", it)); tickin_tx = 1'b0;
                    expect_token(K_TIME, rv, $sformatf("rnd%0d", it));
                end
            endcase
        end
        tx_clk_div = 7'd0;

        tickin_tx = 1'b1; timein_tx = 8'h3F; fct_req = 1'b1; txwrite_tx = 1'b1; data_tx_i = 9'h100;
        dt = 1'b0; df = 1'b0; dd = 1'b0;
        for (int c = 0; c < 400 && order.size() < 3; c++) begin
            step();
            if (dt) tickin_tx = 1'b0;
            if (df) fct_req = 1'b0;
            if (dd) txwrite_tx = 1'b0;
            if ({tick_ack, fct_ack, data_ack} != 3'b000) begin
                chk("prio_onehot", $countones({tick_ack, fct_ack, data_ack}), 1);
                if (tick_ack) begin order.push_back(K_TIME); dt = 1'b1; end
                if (fct_ack) begin order.push_back(K_FCT); df = 1'b1; end
                if (data_ack) begin order.push_back(K_EOP); dd = 1'b1; end
            end
        end
        step();
        tickin_tx = 1'b0; fct_req = 1'b0; txwrite_tx = 1'b0;
        exp_o[0] = K_TIME; exp_o[1] = K_FCT; exp_o[2] = K_EOP;
        chk("prio_count", order.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("prio_order%0d", i), (i < order.size()) ? order[i] : -1, exp_o[i]);
        end
        expect_token(K_TIME, 8'h3F, "prio_tc");
        expect_token(K_FCT, 8'h00, "prio_fct");
        expect_token(K_EOP, 8'h00, "prio_eop");

        send_fct_tx = 1'b0;
        step();
        fct_req = 1'b1;
        fct_ack_cnt = 0;
        repeat (60) step();
        chk("perm_no_fct_ack", fct_ack_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            recv_token(k, v);
            chk($sformatf("perm_null%0d", i), k, K_NULL);
        end
        send_fct_tx = 1'b1;
        wait_ack(1, "perm_fct");
        fct_req = 1'b0;
        expect_token(K_FCT, 8'h00, "perm_fct");

        tx_clk_div = 7'd3;
        repeat (12) step();
        rxt.delete();
        repeat (80) step();
        chk("div_bits", rxt.size() >= 15, 1);
        for (int i = 1; i < rxt.size(); i++) begin
            chk($sformatf("div_gap%0d", i), rxt[i] - rxt[i-1], 4);
        end
        recv_token(k, v); chk("div_tok", k, K_NULL);
        tx_clk_div = 7'd0;

        txwrite_tx = 1'b1; data_tx_i = 9'h0A5;
        wait_ack(0, "abort");
        txwrite_tx = 1'b0;
        repeat (3) step();
        mon_on = 1'b0;
        enable_tx = 1'b0;
        step();
        chk("abort_dout", tx_dout, 0);
        chk("abort_sout", tx_sout, 0);
        repeat (4) step();
        chk("abort_hold", {tx_dout, tx_sout, tick_ack, fct_ack, data_ack}, 0);
        rxq.delete(); rxt.delete();
        last_ds = 1'b0; dec_x = 1'b0; mon_on = 1'b1;
        enable_tx = 1'b1;
        check_first_null("restart");
        recv_token(k, v); chk("restart_tok", k, K_NULL);

        repeat (5) step();
        #3 reset_tx = 1'b1;
        #1;
        chk("async_rst_out", {tx_dout, tx_sout}, 0);
        chk("async_rst_acks", {tick_ack, fct_ack, data_ack}, 0);
        step();
        chk("rst_held", {tx_dout, tx_sout}, 0);
        reset_tx = 1'b0;
        step();
        chk("rst_release", {tx_dout, tx_sout}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
